// File: rtl/mole_anim_sequencer.sv
// Steps one mole sprite through its rise and fall, and commits its position and sprite on frame_start.
// Accept->busy is 1 cycle. cmd_ready drops for ops the current state cannot take (ASCEND waits for IDLE).
module mole_anim_sequencer #(
  parameter int STEP_DIV = 33750,
  parameter int HEIGHT   = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_loc,
  input  logic        frame_start,
  output logic [10:0] x_out,
  output logic [9:0]  y_perm_out,
  output logic [9:0]  y_top_out,
  output logic [1:0]  sprite_sel,
  output logic        visible,
  output logic        busy,
  output logic        done
);

  localparam int               DIV_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(STEP_DIV - 1);
  localparam logic [8:0]       OFF_HIDDEN = 9'(HEIGHT);

  localparam logic [1:0] OP_ASCEND     = 2'd0;
  localparam logic [1:0] OP_DESC_HAPPY = 2'd1;
  localparam logic [1:0] OP_DESC_DEAD  = 2'd2;
  localparam logic [1:0] OP_HIDE       = 2'd3;

  localparam logic [1:0] SPR_NORMAL = 2'd0;
  localparam logic [1:0] SPR_HAPPY  = 2'd1;
  localparam logic [1:0] SPR_DEAD   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RISING,
    S_UP,
    S_FALLING
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [8:0]       r_offset;
  logic [8:0]       w_offset_nxt;
  logic [2:0]       r_slot;
  logic [2:0]       w_slot_nxt;
  logic [1:0]       r_sprite;
  logic [1:0]       w_sprite_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [DIV_W-1:0] r_div;
  logic             w_step_tick;
  logic             w_ready;
  logic             w_accept;
  logic [10:0]      w_slot_x;
  logic [9:0]       w_slot_y;

  logic [10:0]      r_x_out;
  logic [9:0]       r_y_perm_out;
  logic [9:0]       r_y_top_out;
  logic [1:0]       r_sprite_out;
  logic             r_visible;

  // Free-running step divider; commands never restart it.
  assign w_step_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_step_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_comb begin
    w_slot_x = 11'd65;
    w_slot_y = 10'd0;
    case (r_slot)
      3'd0: begin w_slot_x = 11'd65;  w_slot_y = 10'd0;   end
      3'd1: begin w_slot_x = 11'd406; w_slot_y = 10'd0;   end
      3'd2: begin w_slot_x = 11'd747; w_slot_y = 10'd0;   end
      3'd3: begin w_slot_x = 11'd65;  w_slot_y = 10'd256; end
      3'd4: begin w_slot_x = 11'd747; w_slot_y = 10'd256; end
      3'd5: begin w_slot_x = 11'd65;  w_slot_y = 10'd512; end
      3'd6: begin w_slot_x = 11'd406; w_slot_y = 10'd512; end
      default: begin w_slot_x = 11'd747; w_slot_y = 10'd512; end
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:         w_ready = (cmd_op == OP_ASCEND) || (cmd_op == OP_HIDE);
      S_RISING, S_UP: w_ready = (cmd_op != OP_ASCEND);
      S_FALLING:      w_ready = (cmd_op == OP_HIDE);
      default:        w_ready = 1'b0;
    endcase
  end

  assign cmd_ready = w_ready;
  assign w_accept  = cmd_valid & w_ready;

  // An accepted command takes priority; a coincident step tick is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_slot_nxt   = r_slot;
    w_sprite_nxt = r_sprite;
    w_done_nxt   = 1'b0;
    if (w_accept) begin
      case (cmd_op)
        OP_ASCEND: begin
          w_slot_nxt   = cmd_loc;
          w_sprite_nxt = SPR_NORMAL;
          w_offset_nxt = OFF_HIDDEN;
          w_state_nxt  = S_RISING;
        end
        OP_DESC_HAPPY: begin
          w_sprite_nxt = SPR_HAPPY;
          w_state_nxt  = S_FALLING;
        end
        OP_DESC_DEAD: begin
          w_sprite_nxt = SPR_DEAD;
          w_state_nxt  = S_FALLING;
        end
        default: begin
          w_offset_nxt = OFF_HIDDEN;
          w_sprite_nxt = SPR_NORMAL;
          w_state_nxt  = S_IDLE;
        end
      endcase
    end else if (w_step_tick) begin
      case (r_state)
        S_RISING: begin
          if (r_offset <= 9'd1) begin
            w_offset_nxt = 9'd0;
            w_state_nxt  = S_UP;
            w_done_nxt   = 1'b1;
          end else begin
            w_offset_nxt = r_offset - 9'd1;
          end
        end
        S_FALLING: begin
          if (r_offset >= OFF_HIDDEN - 9'd1) begin
            w_offset_nxt = OFF_HIDDEN;
            w_state_nxt  = S_IDLE;
            w_done_nxt   = 1'b1;
          end else begin
            w_offset_nxt = r_offset + 9'd1;
          end
        end
        default: begin
          w_offset_nxt = r_offset;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_offset <= OFF_HIDDEN;
      r_slot   <= 3'd0;
      r_sprite <= SPR_NORMAL;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_offset <= w_offset_nxt;
      r_slot   <= w_slot_nxt;
      r_sprite <= w_sprite_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Display-facing values load from pre-edge state so a frame never sees a half-updated position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x_out      <= 11'd65;
      r_y_perm_out <= 10'd0;
      r_y_top_out  <= 10'd256;
      r_sprite_out <= SPR_NORMAL;
      r_visible    <= 1'b0;
    end else if (frame_start) begin
      r_x_out      <= w_slot_x;
      r_y_perm_out <= w_slot_y;
      r_y_top_out  <= w_slot_y + {1'b0, r_offset};
      r_sprite_out <= r_sprite;
      r_visible    <= (r_offset < OFF_HIDDEN);
    end
  end

  assign x_out      = r_x_out;
  assign y_perm_out = r_y_perm_out;
  assign y_top_out  = r_y_top_out;
  assign sprite_sel = r_sprite_out;
  assign visible    = r_visible;
  assign busy       = (r_state == S_RISING) || (r_state == S_FALLING);
  assign done       = r_done;

endmodule
